agencia_cofre_fsm: RTL



---
 rtl/agencia_cofre_fsm.sv | 122 ++++++++++++
 1 files changed

// File: rtl/agencia_cofre_fsm.sv
// Bank-branch vault supervisor: door violation FSM with grace window,
// minimum-duration siren, manager acknowledge and latched door flags.
module agencia_cofre_fsm #(
   parameter int NCOFRES  = 2,
   parameter int T_TOLER  = 3,
   parameter int T_SIRENE = 8
) (
   input  logic               clk_2,
   input  logic               reset,
   input  logic [NCOFRES-1:0] porta_cofre,
   input  logic               relogio,
   input  logic               interruptor,
   input  logic               reconhece,
   output logic               alarme,
   output logic               sirene,
   output logic [NCOFRES-1:0] cofre_violado,
   output logic [1:0]         estado
);

   localparam int TMAX = (T_SIRENE > T_TOLER) ? T_SIRENE : T_TOLER;
   localparam int CW   = $clog2(TMAX + 1);

   localparam logic [CW-1:0] C_TOL = CW'(T_TOLER - 1);
   localparam logic [CW-1:0] C_SIR = CW'(T_SIRENE);

   localparam logic [1:0] NORMAL     = 2'b00;
   localparam logic [1:0] TOLERANCIA = 2'b01;
   localparam logic [1:0] ALARME     = 2'b10;
   localparam logic [1:0] SILENCIADO = 2'b11;

   logic [1:0]         r_estado;
   logic [CW-1:0]      r_cnt;
   logic [NCOFRES-1:0] r_violado;

   logic [1:0]         w_nxt;
   logic [CW-1:0]      w_cnt_nxt;
   logic [NCOFRES-1:0] w_violado_nxt;
   logic [NCOFRES-1:0] w_viol_vec;
   logic               w_viol;
   logic               w_nova;

   // A door counts as violating when open while armed or out of hours.
   always_comb begin
      w_viol_vec = porta_cofre & {NCOFRES{interruptor | ~relogio}};
      w_viol     = |w_viol_vec;
      w_nova     = |(w_viol_vec & ~r_violado);
   end

   // Next-state and counter logic; cnt restarts whenever ALARME is entered.
   always_comb begin
      w_nxt     = r_estado;
      w_cnt_nxt = r_cnt;
      case (r_estado)
         NORMAL: begin
            w_cnt_nxt = '0;
            if (w_viol)
               w_nxt = interruptor ? ALARME : TOLERANCIA;
         end
         TOLERANCIA: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (interruptor && w_viol)
               w_nxt = ALARME;
            else if (!w_viol)
               w_nxt = NORMAL;
            else if (r_cnt == C_TOL)
               w_nxt = ALARME;
         end
         ALARME: begin
            if (r_cnt != C_SIR)
               w_cnt_nxt = r_cnt + CW'(1);
            else if (reconhece)
               w_nxt = w_viol ? SILENCIADO : NORMAL;
         end
         SILENCIADO: begin
            if (w_nova)
               w_nxt = ALARME;
            else if (!w_viol)
               w_nxt = NORMAL;
         end
         default: begin
            w_nxt     = NORMAL;
            w_cnt_nxt = '0;
         end
      endcase
      if (w_nxt == NORMAL)
         w_cnt_nxt = '0;
      else if (w_nxt == ALARME && r_estado != ALARME)
         w_cnt_nxt = '0;
   end

   // Door flags accumulate while alarmed and clear on return to NORMAL.
   always_comb begin
      w_violado_nxt = r_violado;
      if (w_nxt == NORMAL)
         w_violado_nxt = '0;
      else if (w_nxt == ALARME || r_estado == ALARME ||
               r_estado == SILENCIADO)
         w_violado_nxt = r_violado | w_viol_vec;
   end

   // State, counter and flag registers with synchronous reset.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         r_estado  <= NORMAL;
         r_cnt     <= '0;
         r_violado <= '0;
      end else begin
         r_estado  <= w_nxt;
         r_cnt     <= w_cnt_nxt;
         r_violado <= w_violado_nxt;
      end
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      estado        = r_estado;
      alarme        = r_estado[1];
      sirene        = (r_estado == ALARME);
      cofre_violado = r_violado;
   end

endmodule
